// File: rtl/alu_issue_queue.sv
// Issue queue in front of the combinational 2-bit ALU. Requests wait in a FIFO and issue one per cycle.
// Each ALU result is captured into a registered slot, tagged with the sequence number of its op.
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_a,
    input  logic [1:0]                 in_b,
    input  logic [2:0]                 in_sel,
    output logic [1:0]                 alu_a,
    output logic [1:0]                 alu_b,
    output logic [2:0]                 alu_sel,
    input  logic [4:0]                 alu_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [4:0]                 res_data,
    output logic [TAG_W-1:0]           res_tag,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       busy,
    output logic [1:0]                 dbg_state
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0]       a;
        logic [1:0]       b;
        logic [2:0]       sel;
        logic [TAG_W-1:0] tag;
    } entry_t;

    // valid/ready: a transfer happens on a rising edge where valid & ready are both high.
    // The producer holds its payload until then; ready never waits on valid.
    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [TAG_W-1:0] tag_cnt;
    logic [LW-1:0]    level_n;
    logic             res_valid_n;
    logic             push;
    logic             pop;
    logic             not_empty;
    state_t           state;

    assign not_empty = (level != '0);
    assign head      = mem[rd_ptr];
    // No full bypass: a pop in the same cycle never opens a slot for a push.
    assign in_ready  = (level < LW'(DEPTH)) & ~flush;
    assign push      = in_valid & in_ready;
    assign pop       = not_empty & (~res_valid | res_ready) & ~flush;

    assign alu_a     = not_empty ? head.a   : 2'b00;
    assign alu_b     = not_empty ? head.b   : 2'b00;
    assign alu_sel   = not_empty ? head.sel : 3'b000;
    assign busy      = not_empty | res_valid;
    assign dbg_state = state;

    always_comb begin
        level_n     = level;
        res_valid_n = res_valid;
        if (flush) begin
            level_n     = '0;
            res_valid_n = 1'b0;
        end else begin
            level_n = level + {{(LW-1){1'b0}}, push} - {{(LW-1){1'b0}}, pop};
            if (pop)
                res_valid_n = 1'b1;
            else if (res_valid & res_ready)
                res_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{a: in_a, b: in_b, sel: in_sel, tag: tag_cnt};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            tag_cnt   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_tag   <= '0;
            state     <= IDLE;
        end else begin
            level     <= level_n;
            res_valid <= res_valid_n;
            if (push)
                tag_cnt <= tag_cnt + 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop) begin
                    rd_ptr   <= rd_ptr + 1'b1;
                    res_data <= alu_out;
                    res_tag  <= head.tag;
                end
            end
            // STALL marks a held result with ops still waiting behind it.
            if (level_n == '0 && !res_valid_n)
                state <= IDLE;
            else if (res_valid_n && level_n != '0 && res_valid && !res_ready && !flush)
                state <= STALL;
            else
                state <= RUN;
        end
    end
endmodule
